// File: rtl/ram_xfer.sv
// ram_xfer: block read/write sequencer that drives one client block request onto the cpu_ram_if RAM port.
// Optional per-word abort timer is built in when RAM_XFER_TIMEOUT_EN is defined.

typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
} ramstate_t;

module ram_xfer #(
    parameter int WORDS   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [WORDS*32-1:0]   req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_error,
    output logic [WORDS*32-1:0]   resp_rdata,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    output logic                  ramREN,
    output logic                  ramWEN,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (WORDS < 1 || WORDS > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("ram_xfer: WORDS must be 1..16 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t                state, state_n;
    logic                  write_r;
    logic [31:0]           base_r;
    logic [WORDS*32-1:0]   wdata_r;
    logic [WORDS*32-1:0]   rdata_r;
    logic                  err_r;
    logic [IW-1:0]         idx_r;

    logic                  accept;
    logic                  capture;
    logic                  advance;
    logic                  set_err;
    logic                  last_word;
    logic                  expired;
    logic [31:0]           word_addr;

    assign last_word = (idx_r == IW'(WORDS - 1));
    assign word_addr = base_r + {{(30 - IW){1'b0}}, idx_r, 2'b00};

`ifdef RAM_XFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_r;

    // Counts cycles spent on the current word; any state other than XFER or a word advance restarts it.
    always_ff @(posedge CLK) begin
        if (!nRST || state != XFER || advance) begin
            tcnt_r <= '0;
        end else begin
            tcnt_r <= tcnt_r + 1'b1;
        end
    end

    assign expired = (tcnt_r == TW'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        set_err = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = XFER;
                end
            end
            XFER: begin
                if (ramstate == ACCESS) begin
                    capture = !write_r;
                    if (last_word) begin
                        state_n = RESP;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (ramstate == ERROR || expired) begin
                    set_err = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, word index and gathered read data.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            write_r <= 1'b0;
            base_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            idx_r   <= '0;
        end else begin
            if (accept) begin
                write_r <= req_write;
                base_r  <= req_addr & ~32'h3;
                wdata_r <= req_wdata;
                rdata_r <= '0;
                err_r   <= 1'b0;
                idx_r   <= '0;
            end
            if (capture) begin
                rdata_r[32*int'(idx_r) +: 32] <= ramload;
            end
            if (advance) begin
                idx_r <= idx_r + 1'b1;
            end
            if (set_err) begin
                err_r <= 1'b1;
            end
        end
    end

    // Everything below decodes registered state only, so the RAM side never sees a request or ramstate path.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_error = err_r;
    assign resp_rdata = rdata_r;
    assign ramREN     = (state == XFER) && !write_r;
    assign ramWEN     = (state == XFER) && write_r;
    assign ramaddr    = (state == XFER) ? word_addr : '0;
    assign ramstore   = (state == XFER) ? wdata_r[32*int'(idx_r) +: 32] : '0;

endmodule
